wb_rr_arbiter_n: RTL
====================

Name: wb_rr_arbiter_n

Overview:
- Parametrised N-master WISHBONE bus arbiter with registered grants and zero-overhead hand-over. Next generation of the four-level round-robin arbiter.
- Adds: arbitrary master count, per-master request masking, a runtime fixed-priority mode, and a bus-tenure watchdog that flags over-long cycles.
- Sits between the master CYC lines and the shared-bus interconnect; COMCYC and the encoded grant drive the interconnect muxes.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..32).
- MAX_HOLD, 0, tenure watchdog limit in clocks; 0 disables the watchdog.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- CYC  in  NUM_MASTERS  per-master bus request (WISHBONE CYC_O).
- MASK  in  NUM_MASTERS  1 = master excluded from new arbitration.
- FIXPRI  in  1  0 = round-robin; 1 = fixed priority, index 0 highest.
- COMCYC  out  1  common cycle: granted master is asserting CYC.
- GNT  out  IDX_W  binary index of granted master; IDX_W = max(1, clog2(NUM_MASTERS)).
- GNT_OH  out  NUM_MASTERS  one-hot grant, registered.
- GNT_VLD  out  1  OR of GNT_OH.
- HOLD_TMO  out  1  one-cycle pulse: tenure reached MAX_HOLD while another unmasked master waits.

Behaviour:
- Reset: GNT_OH=0, GNT=0, GNT_VLD=0, COMCYC=0, HOLD_TMO=0, LAST pointer=NUM_MASTERS-1, hold counter=0. With all masters requesting, master 0 wins first.
- COMCYC = OR over i of (CYC[i] & GNT_OH[i]); combinational from the registers and CYC.
- GNT = binary encoding of GNT_OH, combinational; GNT=0 when GNT_VLD=0.
- Hold (COMCYC=1): GNT_OH keeps its value. MASK and FIXPRI changes never revoke a live grant.
- Arbitration (COMCYC=0):
  - Candidate set REQ = CYC & ~MASK.
  - Round-robin (FIXPRI=0): the winner is the first set bit of REQ scanning LAST+1, LAST+2, … with modulo-NUM_MASTERS wrap.
  - Fixed priority (FIXPRI=1): the winner is the lowest set index of REQ.
  - GNT_OH <= onehot(winner), or 0 if REQ=0.
  - LAST <= winner on every cycle a new non-zero grant is loaded, in both modes.
- Latency: one clock from request (bus idle) to GNT_OH.
- Hand-over: when the owner drops CYC, COMCYC falls in that cycle and the next winner is loaded on the following edge. There is no extra idle cycle.
- Stale grant: a granted master that never asserts CYC keeps COMCYC=0, so it is re-arbitrated every cycle. The grant moves if another candidate exists; otherwise it falls to 0.
- Simultaneous events: owner releasing in the same cycle another master raises CYC → normal arbitration. The releasing master is eligible only after all others in RR order.
- Watchdog (MAX_HOLD>0):
  - Counter CNT (width clog2(MAX_HOLD+1)) increments each cycle COMCYC=1 and saturates at MAX_HOLD; it clears when COMCYC=0.
  - HOLD_TMO is registered and pulses exactly once per tenure: on the edge after CNT reaches MAX_HOLD, with (CYC & ~MASK & ~GNT_OH) non-zero at that point.
  - If no waiter exists at saturation, it pulses on the first later cycle a waiter appears, still once per tenure.
  - The grant is not revoked.
- Watchdog disabled (MAX_HOLD=0): HOLD_TMO is constant 0 and the counter is absent.
- Reset mid-tenure: all state returns to reset values at the next edge, regardless of CYC.

Decomposition:
- Package wb_arb_pkg: clog2 function, IDX_W derivation, onehot-to-binary encode function.
- Sub-module wb_rr_pick (combinational): inputs REQ, LAST, FIXPRI; outputs winner one-hot plus valid.
- Sequential state stays in the top: GNT_OH, LAST, CNT, the tenure-flag register, and HOLD_TMO.

Test Plan:
- Reset release, CYC=4'b1111, MASK=0, FIXPRI=0; each owner drops CYC for one cycle then re-requests → grant order 0,1,2,3,0. GNT_OH appears one clock after its request; COMCYC is high whenever the owner asserts CYC.
- Owner 2 drops CYC while CYC[3] and CYC[0] are high → next edge GNT=3. Then 3 drops → GNT=0 (wrap). No idle edge between owners.
- FIXPRI=1, CYC=4'b1010 → GNT=1. After release with CYC[3] still high and CYC[1] re-raised → GNT=1 again.
- MASK=4'b0010, CYC=4'b0010 → GNT_VLD stays 0. MASK set on the current owner mid-tenure → grant held until it drops CYC.
- MAX_HOLD=8, master 0 holds for 20 clocks, CYC[1] raised at tenure clock 3 → HOLD_TMO is a single pulse when CNT reaches 8, the grant is unchanged, and no second pulse occurs. Repeat with no waiter → HOLD_TMO stays 0.
- RST asserted for one cycle mid-tenure → GNT_OH=0, COMCYC=0, next grant follows LAST=NUM_MASTERS-1 (master 0 first if requesting).

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared helpers for the WISHBONE arbiter family.
//   f_clog2  : ceiling log2 of a positive integer (f_clog2(1) = 0)
//   f_idx_w  : width of a binary master index, never less than 1
//   f_oh2bin : one-hot (up to 32 bits) to binary index; 0 for an all-zero input
package wb_arb_pkg;

  function automatic int unsigned f_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v > (32'd1 << i)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned f_idx_w(input int unsigned n);
    return (n < 2) ? 1 : f_clog2(n);
  endfunction

  // OR of the indices of the set bits, so a zero vector encodes to 0.
  function automatic logic [4:0] f_oh2bin(input logic [31:0] oh);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) r = r | 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational winner selection for wb_rr_arbiter_n.
//   i_req     : candidate requests (already masked)
//   i_last    : index of the most recent winner (round-robin origin)
//   i_fixpri  : 1 = lowest index wins, 0 = rotate starting after i_last
//   o_win_oh  : one-hot winner, zero when no candidate
//   o_win_vld : at least one candidate
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDX_W       = f_idx_w(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]       i_last,
  input  logic                   i_fixpri,
  output logic [NUM_MASTERS-1:0] o_win_oh,
  output logic                   o_win_vld
);

  always_comb begin : p_pick
    logic        found;
    int unsigned idx;
    o_win_oh = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      // Fixed priority scans 0..N-1; round-robin scans LAST+1.. with wrap.
      idx = i_fixpri ? k : ((32'(i_last) + 1 + k) % NUM_MASTERS);
      if (!found && i_req[IDX_W'(idx)]) begin
        o_win_oh[IDX_W'(idx)] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

  assign o_win_vld = |i_req;

endmodule

// File: rtl/wb_rr_arbiter_n.sv
// N-master WISHBONE bus arbiter with registered grants.
//   CLK, RST : clock (rising edge), synchronous active-high reset
//   CYC      : per-master bus request
//   MASK     : 1 = master excluded from new arbitration
//   FIXPRI   : 0 = round-robin, 1 = fixed priority (index 0 highest)
//   COMCYC   : granted master is asserting CYC
//   GNT      : binary index of the granted master (0 when none)
//   GNT_OH   : registered one-hot grant
//   GNT_VLD  : any grant held
//   HOLD_TMO : one-cycle pulse when a tenure reaches MAX_HOLD while another
//              unmasked master waits (MAX_HOLD = 0 disables it)
module wb_rr_arbiter_n
  import wb_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = 4,
  parameter  int unsigned MAX_HOLD    = 0,
  localparam int unsigned IDX_W       = f_idx_w(NUM_MASTERS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_MASTERS-1:0] CYC,
  input  logic [NUM_MASTERS-1:0] MASK,
  input  logic                   FIXPRI,
  output logic                   COMCYC,
  output logic [IDX_W-1:0]       GNT,
  output logic [NUM_MASTERS-1:0] GNT_OH,
  output logic                   GNT_VLD,
  output logic                   HOLD_TMO
);

  logic [NUM_MASTERS-1:0] r_gnt_oh;
  logic [IDX_W-1:0]       r_last;
  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic                   w_win_vld;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_comcyc;

  assign w_req     = CYC & ~MASK;
  assign w_comcyc  = |(CYC & r_gnt_oh);
  assign w_win_idx = IDX_W'(f_oh2bin(32'(w_win_oh)));

  wb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .i_req     (w_req),
    .i_last    (r_last),
    .i_fixpri  (FIXPRI),
    .o_win_oh  (w_win_oh),
    .o_win_vld (w_win_vld)
  );

  // Re-arbitrate on every cycle the bus is not in use, including a stale
  // grant whose owner never raised CYC; a live tenure is never revoked.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_gnt_oh <= '0;
      r_last   <= IDX_W'(NUM_MASTERS - 1);
    end else if (!w_comcyc) begin
      r_gnt_oh <= w_win_oh;
      if (w_win_vld) r_last <= w_win_idx;
    end
  end

  generate
    if (MAX_HOLD > 0) begin : g_wdog
      localparam int unsigned CNT_W = f_clog2(MAX_HOLD + 1);
      logic [CNT_W-1:0] r_cnt;
      logic             r_tmo_done;
      logic             r_hold_tmo;
      logic             w_sat;
      logic             w_waiter;

      assign w_sat    = (r_cnt == CNT_W'(MAX_HOLD));
      assign w_waiter = |(CYC & ~MASK & ~r_gnt_oh);

      // r_tmo_done limits the pulse to one per tenure even if the waiter
      // only shows up after the counter has saturated.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_cnt      <= '0;
          r_tmo_done <= 1'b0;
          r_hold_tmo <= 1'b0;
        end else begin
          r_hold_tmo <= 1'b0;
          if (!w_comcyc) begin
            r_cnt      <= '0;
            r_tmo_done <= 1'b0;
          end else begin
            if (!w_sat) r_cnt <= r_cnt + 1'b1;
            if (w_sat && w_waiter && !r_tmo_done) begin
              r_hold_tmo <= 1'b1;
              r_tmo_done <= 1'b1;
            end
          end
        end
      end

      assign HOLD_TMO = r_hold_tmo;
    end else begin : g_no_wdog
      assign HOLD_TMO = 1'b0;
    end
  endgenerate

  assign GNT_OH  = r_gnt_oh;
  assign GNT_VLD = |r_gnt_oh;
  assign GNT     = IDX_W'(f_oh2bin(32'(r_gnt_oh)));
  assign COMCYC  = w_comcyc;

endmodule
